// File: rtl/dmem_slot_arbiter_pkg.sv
// dmem_arb_pkg: shared types and default sizes for dmem_slot_arbiter.
package dmem_arb_pkg;

    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_DEPTH  = 140001;

    typedef enum logic {
        RUN    = 1'b0,
        REPLAY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } mem_op_t;

    // True when a word address lies beyond the populated part of the BRAM.
    function automatic logic addr_oob(input logic [DMEM_ADDR_W-1:0] addr,
                                      input int unsigned depth);
        return addr >= DMEM_ADDR_W'(depth);
    endfunction

endpackage

// File: rtl/dmem_slot_arbiter_if.sv
// dmem_slot_arbiter_if: execute-stage side of the data-memory arbiter
// (two slot requests in, stall and per-slot load results out).
interface dmem_slot_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DMEM_DATA_W,
    parameter int unsigned ADDR_W = DMEM_ADDR_W
);
    logic              s0_req;
    logic              s0_we;
    logic [ADDR_W-1:0] s0_addr;
    logic [DATA_W-1:0] s0_wdata;
    logic              s1_req;
    logic              s1_we;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_wdata;
    logic              stall;
    logic              r0_valid;
    logic [DATA_W-1:0] r0_data;
    logic              r1_valid;
    logic [DATA_W-1:0] r1_data;

    modport master (
        output s0_req, s0_we, s0_addr, s0_wdata,
        output s1_req, s1_we, s1_addr, s1_wdata,
        input  stall, r0_valid, r0_data, r1_valid, r1_data
    );

    modport slave (
        input  s0_req, s0_we, s0_addr, s0_wdata,
        input  s1_req, s1_we, s1_addr, s1_wdata,
        output stall, r0_valid, r0_data, r1_valid, r1_data
    );
endinterface

// File: rtl/dmem_slot_arbiter_conflict_detect.sv
// dmem_conflict_detect: classifies a slot pair as needing serialisation
// (conflict) or as a store-to-load forward within one cycle.
module dmem_conflict_detect
    import dmem_arb_pkg::*;
(
    input  logic    s0_req,
    input  mem_op_t op0,
    input  logic    s1_req,
    input  mem_op_t op1,
    output logic    conflict,
    output logic    forward
);

    logic both;
    logic same_addr;

    // Two stores or two loads need the same BRAM port; an earlier load with a
    // later store to the same word must see the old value, so it is split too.
    always_comb begin
        both      = s0_req && s1_req;
        same_addr = (op0.addr == op1.addr);
        conflict  = both && ((op0.we == op1.we) || (!op0.we && op1.we && same_addr));
        forward   = both && op0.we && !op1.we && same_addr;
    end

endmodule

// File: rtl/dmem_slot_arbiter.sv
// dmem_slot_arbiter: shares a simple dual-port data BRAM (A write, B read,
// 1-cycle read) between two VLIW memory slots, with one-cycle replay on
// port conflicts and same-cycle store-to-load forwarding.
// Optional macro DMEM_ARB_STATS_EN adds stall_cnt / fwd_cnt counters.
module dmem_slot_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DMEM_DATA_W,
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    dmem_slot_arbiter_if.slave bus,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dia,
    output logic              ram_enb,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_dob,
    output logic              oob_err
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt
`endif
);

    arb_state_e        state_q, state_d;
    mem_op_t           rep_q, rep_d;
    logic              r0_valid_q, r0_valid_d, r0_zero_q, r0_zero_d;
    logic              r1_valid_q, r1_valid_d, r1_zero_q, r1_zero_d;
    logic              r1_fwd_q, r1_fwd_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic              oob_err_q, oob_err_d;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]       stall_cnt_q, stall_cnt_d;
    logic [31:0]       fwd_cnt_q, fwd_cnt_d;
`endif

    mem_op_t op0, op1, iss1_op;
    logic    conflict, forward;
    logic    iss0_v, iss1_v, fwd_now, stall_now;
    logic    oob0, oob1;

    // Pack the slot inputs into op records.
    always_comb begin
        op0.we    = bus.s0_we;
        op0.addr  = bus.s0_addr;
        op0.wdata = bus.s0_wdata;
        op1.we    = bus.s1_we;
        op1.addr  = bus.s1_addr;
        op1.wdata = bus.s1_wdata;
    end

    dmem_conflict_detect u_conflict (
        .s0_req   (bus.s0_req),
        .op0      (op0),
        .s1_req   (bus.s1_req),
        .op1      (op1),
        .conflict (conflict),
        .forward  (forward)
    );

    // Range check of the slot0 op and of whichever op issues on slot1.
    always_comb begin
        oob0 = addr_oob(op0.addr, DEPTH);
        oob1 = addr_oob(iss1_op.addr, DEPTH);
    end

    // FSM next state: decide what issues this cycle and whether to stall.
    always_comb begin
        state_d   = state_q;
        rep_d     = rep_q;
        iss0_v    = 1'b0;
        iss1_v    = 1'b0;
        iss1_op   = op1;
        fwd_now   = 1'b0;
        stall_now = 1'b0;
        case (state_q)
            RUN: begin
                iss0_v = bus.s0_req;
                if (conflict) begin
                    rep_d     = op1;
                    stall_now = 1'b1;
                    state_d   = REPLAY;
                end else begin
                    iss1_v  = bus.s1_req;
                    // An out-of-range store writes nothing, so nothing to forward.
                    fwd_now = forward && !oob0;
                end
            end
            REPLAY: begin
                iss1_v  = 1'b1;
                iss1_op = rep_q;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // BRAM port drive: at most one store and one BRAM read issue per cycle.
    always_comb begin
        ram_ena   = 1'b0;
        ram_wea   = 1'b0;
        ram_addra = '0;
        ram_dia   = '0;
        ram_enb   = 1'b0;
        ram_addrb = '0;
        if (iss0_v && op0.we && !oob0) begin
            ram_ena   = 1'b1;
            ram_wea   = 1'b1;
            ram_addra = op0.addr;
            ram_dia   = op0.wdata;
        end else if (iss1_v && iss1_op.we && !oob1) begin
            ram_ena   = 1'b1;
            ram_wea   = 1'b1;
            ram_addra = iss1_op.addr;
            ram_dia   = iss1_op.wdata;
        end
        if (iss0_v && !op0.we && !oob0) begin
            ram_enb   = 1'b1;
            ram_addrb = op0.addr;
        end else if (iss1_v && !iss1_op.we && !oob1 && !fwd_now) begin
            ram_enb   = 1'b1;
            ram_addrb = iss1_op.addr;
        end
    end

    // Return-path and status next values, registered alongside the issue.
    always_comb begin
        r0_valid_d = iss0_v && !op0.we;
        r0_zero_d  = oob0;
        r1_valid_d = iss1_v && !iss1_op.we;
        r1_zero_d  = oob1;
        r1_fwd_d   = fwd_now;
        fwd_data_d = op0.wdata;
        oob_err_d  = oob_err_q || (iss0_v && oob0) || (iss1_v && oob1);
`ifdef DMEM_ARB_STATS_EN
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_now) stall_cnt_d = stall_cnt_q + 32'd1;
        if (fwd_now)   fwd_cnt_d   = fwd_cnt_q + 32'd1;
`endif
    end

    // Load data is selected in the return cycle from BRAM, forward register or zero.
    always_comb begin
        bus.stall    = stall_now;
        bus.r0_valid = r0_valid_q;
        bus.r1_valid = r1_valid_q;
        bus.r0_data  = '0;
        bus.r1_data  = '0;
        if (r0_valid_q && !r0_zero_q) bus.r0_data = ram_dob;
        if (r1_valid_q && !r1_zero_q) bus.r1_data = r1_fwd_q ? fwd_data_q : ram_dob;
        oob_err = oob_err_q;
`ifdef DMEM_ARB_STATS_EN
        stall_cnt = stall_cnt_q;
        fwd_cnt   = fwd_cnt_q;
`endif
    end

    // State, replay register and return-path registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            rep_q       <= '0;
            r0_valid_q  <= 1'b0;
            r0_zero_q   <= 1'b0;
            r1_valid_q  <= 1'b0;
            r1_zero_q   <= 1'b0;
            r1_fwd_q    <= 1'b0;
            fwd_data_q  <= '0;
            oob_err_q   <= 1'b0;
`ifdef DMEM_ARB_STATS_EN
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rep_q       <= rep_d;
            r0_valid_q  <= r0_valid_d;
            r0_zero_q   <= r0_zero_d;
            r1_valid_q  <= r1_valid_d;
            r1_zero_q   <= r1_zero_d;
            r1_fwd_q    <= r1_fwd_d;
            fwd_data_q  <= fwd_data_d;
            oob_err_q   <= oob_err_d;
`ifdef DMEM_ARB_STATS_EN
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_slot_arbiter.sv
// tb_dmem_slot_arbiter: directed and randomized bench for dmem_slot_arbiter.
// Randomized checking uses a program-order memory model: slot0 then slot1,
// out-of-range stores dropped, out-of-range loads reading 0.
module tb_dmem_slot_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned DEPTH = 140001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_ena, ram_wea, ram_enb;
    logic [31:0] ram_addra, ram_dia, ram_addrb;
    logic [31:0] ram_dob = '0;
    logic        oob_err;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_slot_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    dmem_slot_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dia   (ram_dia),
        .ram_enb   (ram_enb),
        .ram_addrb (ram_addrb),
        .ram_dob   (ram_dob),
        .oob_err   (oob_err)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt)
`endif
    );

    // Simple dual-port BRAM with registered read.
    logic [31:0] bram [logic [31:0]];
    int unsigned wr_cnt = 0;
    int unsigned rd_cnt = 0;
    always @(posedge clk) begin
        if (ram_enb) begin
            ram_dob <= bram.exists(ram_addrb) ? bram[ram_addrb] : 32'h0;
            rd_cnt++;
        end
        if (ram_ena && ram_wea) begin
            bram[ram_addra] = ram_dia;
            wr_cnt++;
        end
    end

    // Reference memory for the randomized test.
    logic [31:0] ref_mem [logic [31:0]];
    bit          ref_oob;

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d);
        if (a < DEPTH) ref_mem[a] = d;
        else           ref_oob = 1'b1;
    endtask

    task automatic ref_load(input logic [31:0] a, output logic [31:0] v);
        if (a >= DEPTH) begin
            ref_oob = 1'b1;
            v = '0;
        end else begin
            v = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
        end
    endtask

    function automatic logic [31:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 6)  return r;
        if (r == 6) return DEPTH - 1;
        if (r == 7) return DEPTH;
        if (r == 8) return DEPTH + 1;
        return 32'hFFFF_FFFF;
    endfunction

    task automatic drive(input bit q0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit q1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
        bus.s0_req = q0; bus.s0_we = w0; bus.s0_addr = a0; bus.s0_wdata = d0;
        bus.s1_req = q1; bus.s1_we = w1; bus.s1_addr = a1; bus.s1_wdata = d1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        tests++; if (bus.stall !== 1'b0)    begin fails++; $display("FAIL rst_stall got %b want 0", bus.stall); end
        tests++; if (bus.r0_valid !== 1'b0) begin fails++; $display("FAIL rst_r0_valid got %b want 0", bus.r0_valid); end
        tests++; if (bus.r1_valid !== 1'b0) begin fails++; $display("FAIL rst_r1_valid got %b want 0", bus.r1_valid); end
        tests++; if (bus.r0_data !== 32'h0) begin fails++; $display("FAIL rst_r0_data got %h want 0", bus.r0_data); end
        tests++; if (bus.r1_data !== 32'h0) begin fails++; $display("FAIL rst_r1_data got %h want 0", bus.r1_data); end
        tests++; if (oob_err !== 1'b0)      begin fails++; $display("FAIL rst_oob got %b want 0", oob_err); end
        tests++; if ({ram_ena, ram_wea, ram_enb} !== 3'b000) begin fails++; $display("FAIL rst_ram_en got %b want 000", {ram_ena, ram_wea, ram_enb}); end
`ifdef DMEM_ARB_STATS_EN
        tests++; if (stall_cnt !== 32'h0 || fwd_cnt !== 32'h0) begin fails++; $display("FAIL rst_counters got %0d/%0d want 0/0", stall_cnt, fwd_cnt); end
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_load_no_conflict();
        @(posedge clk); #1;
        bram[32'h20] = 32'h55;
        drive(1, 1, 32'h10, 32'hAAAA, 1, 0, 32'h20, 0);
        @(negedge clk);
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL sl_stall got %b want 0", bus.stall); end
        tests++; if (ram_ena !== 1'b1 || ram_wea !== 1'b1 || ram_addra !== 32'h10 || ram_dia !== 32'hAAAA) begin
            fails++; $display("FAIL sl_porta got en=%b we=%b a=%h d=%h want 1 1 10 aaaa", ram_ena, ram_wea, ram_addra, ram_dia); end
        tests++; if (ram_enb !== 1'b1 || ram_addrb !== 32'h20) begin fails++; $display("FAIL sl_portb got en=%b a=%h want 1 20", ram_enb, ram_addrb); end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tests++; if (bus.r1_valid !== 1'b1 || bus.r1_data !== 32'h55) begin fails++; $display("FAIL sl_r1 got v=%b d=%h want 1 55", bus.r1_valid, bus.r1_data); end
        tests++; if (bus.r0_valid !== 1'b0) begin fails++; $display("FAIL sl_r0_valid got %b want 0", bus.r0_valid); end
        tests++; if (bram[32'h10] !== 32'hAAAA) begin fails++; $display("FAIL sl_mem got %h want aaaa", bram[32'h10]); end
    endtask

    task automatic test_load_load();
        int unsigned rd0;
        @(posedge clk); #1;
        bram[32'h8] = 32'h11;
        bram[32'h9] = 32'h22;
        rd0 = rd_cnt;
        drive(1, 0, 32'h8, 0, 1, 0, 32'h9, 0);
        @(negedge clk);
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL ll_stall got %b want 1", bus.stall); end
        tests++; if (ram_enb !== 1'b1 || ram_addrb !== 32'h8) begin fails++; $display("FAIL ll_rd0 got en=%b a=%h want 1 8", ram_enb, ram_addrb); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL ll_replay_stall got %b want 0", bus.stall); end
        tests++; if (ram_enb !== 1'b1 || ram_addrb !== 32'h9) begin fails++; $display("FAIL ll_rd1 got en=%b a=%h want 1 9", ram_enb, ram_addrb); end
        tests++; if (bus.r0_valid !== 1'b1 || bus.r0_data !== 32'h11 || bus.r1_valid !== 1'b0) begin
            fails++; $display("FAIL ll_r0 got v=%b d=%h r1v=%b want 1 11 0", bus.r0_valid, bus.r0_data, bus.r1_valid); end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tests++; if (bus.r1_valid !== 1'b1 || bus.r1_data !== 32'h22 || bus.r0_valid !== 1'b0) begin
            fails++; $display("FAIL ll_r1 got v=%b d=%h r0v=%b want 1 22 0", bus.r1_valid, bus.r1_data, bus.r0_valid); end
        tests++; if (rd_cnt - rd0 !== 2) begin fails++; $display("FAIL ll_reads got %0d want 2", rd_cnt - rd0); end
    endtask

    task automatic test_forward();
        @(posedge clk); #1;
        bram[32'h30] = 32'h0BAD;
        drive(1, 1, 32'h30, 32'h1234, 1, 0, 32'h30, 0);
        @(negedge clk);
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL fwd_stall got %b want 0", bus.stall); end
        tests++; if (ram_enb !== 1'b0 || ram_ena !== 1'b1) begin fails++; $display("FAIL fwd_ports got enb=%b ena=%b want 0 1", ram_enb, ram_ena); end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tests++; if (bus.r1_valid !== 1'b1 || bus.r1_data !== 32'h1234) begin fails++; $display("FAIL fwd_r1 got v=%b d=%h want 1 1234", bus.r1_valid, bus.r1_data); end
    endtask

    task automatic test_load_store_same();
        @(posedge clk); #1;
        bram[32'h40] = 32'h7;
        drive(1, 0, 32'h40, 0, 1, 1, 32'h40, 32'h9);
        @(negedge clk);
        tests++; if (bus.stall !== 1'b1 || ram_ena !== 1'b0 || ram_enb !== 1'b1) begin
            fails++; $display("FAIL ls_first got stall=%b ena=%b enb=%b want 1 0 1", bus.stall, ram_ena, ram_enb); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (bus.stall !== 1'b0 || ram_ena !== 1'b1 || ram_addra !== 32'h40 || ram_dia !== 32'h9) begin
            fails++; $display("FAIL ls_replay got stall=%b ena=%b a=%h d=%h want 0 1 40 9", bus.stall, ram_ena, ram_addra, ram_dia); end
        tests++; if (bus.r0_valid !== 1'b1 || bus.r0_data !== 32'h7) begin fails++; $display("FAIL ls_r0 got v=%b d=%h want 1 7", bus.r0_valid, bus.r0_data); end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tests++; if (bram[32'h40] !== 32'h9) begin fails++; $display("FAIL ls_mem got %h want 9", bram[32'h40]); end
    endtask

    task automatic test_oob();
        int unsigned wr0;
        @(posedge clk); #1;
        wr0 = wr_cnt;
        drive(1, 1, DEPTH, 32'hDEAD, 0, 0, 0, 0);
        @(negedge clk);
        tests++; if (ram_ena !== 1'b0 || bus.stall !== 1'b0) begin fails++; $display("FAIL oob_store got ena=%b stall=%b want 0 0", ram_ena, bus.stall); end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 1, 0, DEPTH, 0);
        @(negedge clk);
        tests++; if (oob_err !== 1'b1) begin fails++; $display("FAIL oob_flag got %b want 1", oob_err); end
        tests++; if (ram_enb !== 1'b0) begin fails++; $display("FAIL oob_load_rd got %b want 0", ram_enb); end
        @(posedge clk); #1;
        drive(1, 1, DEPTH - 1, 32'hBEEF, 0, 0, 0, 0);
        @(negedge clk);
        tests++; if (bus.r1_valid !== 1'b1 || bus.r1_data !== 32'h0) begin fails++; $display("FAIL oob_load got v=%b d=%h want 1 0", bus.r1_valid, bus.r1_data); end
        tests++; if (ram_ena !== 1'b1 || ram_addra !== DEPTH - 1) begin fails++; $display("FAIL oob_edge_store got ena=%b a=%0d want 1 %0d", ram_ena, ram_addra, DEPTH - 1); end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (oob_err !== 1'b1) begin fails++; $display("FAIL oob_sticky got %b want 1", oob_err); end
        tests++; if (wr_cnt - wr0 !== 1) begin fails++; $display("FAIL oob_writes got %0d want 1", wr_cnt - wr0); end
    endtask

    task automatic test_reset_in_replay();
        int unsigned wr0;
        @(posedge clk); #1;
        bram[32'h50] = 32'h3;
        wr0 = wr_cnt;
        drive(1, 0, 32'h50, 0, 1, 1, 32'h50, 32'h77);
        @(negedge clk);
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL rr_stall got %b want 1", bus.stall); end
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        tests++; if (bus.r0_valid !== 1'b0 || bus.r0_data !== 32'h0) begin fails++; $display("FAIL rr_r0 got v=%b d=%h want 0 0", bus.r0_valid, bus.r0_data); end
        tests++; if ({ram_ena, ram_enb, bus.stall} !== 3'b000) begin fails++; $display("FAIL rr_outputs got %b want 000", {ram_ena, ram_enb, bus.stall}); end
        tests++; if (oob_err !== 1'b0) begin fails++; $display("FAIL rr_oob got %b want 0", oob_err); end
`ifdef DMEM_ARB_STATS_EN
        tests++; if (stall_cnt !== 32'h0 || fwd_cnt !== 32'h0) begin fails++; $display("FAIL rr_counters got %0d/%0d want 0/0", stall_cnt, fwd_cnt); end
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (wr_cnt - wr0 !== 0 || bram[32'h50] !== 32'h3) begin
            fails++; $display("FAIL rr_dropped got writes=%0d mem=%h want 0 3", wr_cnt - wr0, bram[32'h50]); end
    endtask

    task automatic test_random();
        logic [31:0] a0, a1, d0, d1, nd0, nd1, e0d, e1d;
        bit          q0, q1, w0, w1, conf, nv0, nv1, e0v, e1v, issue1;
        int unsigned estall, efwd, ncyc;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bram.delete();
        ref_mem.delete();
        for (int unsigned k = 0; k < 6; k++) begin
            bram[k] = $urandom;
            ref_mem[k] = bram[k];
        end
        ref_oob = 1'b0;
        e0v = 1'b0; e1v = 1'b0; e0d = '0; e1d = '0;
        estall = 0; efwd = 0;
        for (int i = 0; i < 400; i++) begin
            q0 = (i < 398) && ($urandom_range(0, 3) != 0);
            q1 = (i < 398) && ($urandom_range(0, 3) != 0);
            w0 = ($urandom_range(0, 1) == 1);
            w1 = ($urandom_range(0, 1) == 1);
            a0 = pick_addr();
            a1 = pick_addr();
            d0 = $urandom;
            d1 = $urandom;
            conf = q0 && q1 && ((w0 == w1) || (!w0 && w1 && a0 == a1));
            ncyc = conf ? 2 : 1;
            @(posedge clk); #1;
            drive(q0, w0, a0, d0, q1, w1, a1, d1);
            for (int unsigned c = 0; c < ncyc; c++) begin
                if (c == 1) begin
                    @(posedge clk); #1;
                    drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pick_addr(), $urandom,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pick_addr(), $urandom);
                end
                @(negedge clk);
                tests++; if (bus.stall !== (conf && c == 0)) begin fails++; $display("FAIL rnd_stall b%0d c%0d got %b want %b", i, c, bus.stall, conf && c == 0); end
                tests++; if (bus.r0_valid !== e0v) begin fails++; $display("FAIL rnd_r0_valid b%0d c%0d got %b want %b", i, c, bus.r0_valid, e0v); end
                if (e0v) begin
                    tests++; if (bus.r0_data !== e0d) begin fails++; $display("FAIL rnd_r0_data b%0d c%0d got %h want %h", i, c, bus.r0_data, e0d); end
                end
                tests++; if (bus.r1_valid !== e1v) begin fails++; $display("FAIL rnd_r1_valid b%0d c%0d got %b want %b", i, c, bus.r1_valid, e1v); end
                if (e1v) begin
                    tests++; if (bus.r1_data !== e1d) begin fails++; $display("FAIL rnd_r1_data b%0d c%0d got %h want %h", i, c, bus.r1_data, e1d); end
                end
                tests++; if (oob_err !== ref_oob) begin fails++; $display("FAIL rnd_oob b%0d c%0d got %b want %b", i, c, oob_err, ref_oob); end
`ifdef DMEM_ARB_STATS_EN
                tests++; if (stall_cnt !== estall || fwd_cnt !== efwd) begin
                    fails++; $display("FAIL rnd_counters b%0d c%0d got %0d/%0d want %0d/%0d", i, c, stall_cnt, fwd_cnt, estall, efwd); end
`endif
                nv0 = 1'b0; nv1 = 1'b0; nd0 = '0; nd1 = '0;
                if (c == 0 && q0) begin
                    if (w0) ref_store(a0, d0);
                    else begin nv0 = 1'b1; ref_load(a0, nd0); end
                end
                issue1 = q1 && (conf ? (c == 1) : 1'b1);
                if (issue1) begin
                    if (w1) ref_store(a1, d1);
                    else begin nv1 = 1'b1; ref_load(a1, nd1); end
                end
                if (c == 0 && conf) estall++;
                if (c == 0 && q0 && q1 && w0 && !w1 && a0 == a1 && a0 < DEPTH) efwd++;
                e0v = nv0; e0d = nd0; e1v = nv1; e1d = nd1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_store_load_no_conflict();
        test_load_load();
        test_forward();
        test_load_store_same();
        test_oob();
        test_reset_in_replay();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_slot_arbiter.md
Name: dmem_slot_arbiter

Overview:
- Shares the core's simple dual-port data BRAM (port A write-only, port B read-only, 1-cycle registered read) between the two VLIW memory slots.
- Per cycle: at most one write, on port A, and at most one read, on port B.
- Serialises conflicting slot pairs with a one-cycle stall/replay.
- Forwards same-cycle store data to a program-later load.
- Sits between the VLIW execute stage and the data memory instance.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 32, address port width (word address).
- DEPTH, 140001, number of valid words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- s0_req/s1_req  in  1  slot memory op valid (slot0 is program-earlier)
- s0_we/s1_we  in  1  1=store, 0=load
- s0_addr/s1_addr  in  ADDR_W  word address
- s0_wdata/s1_wdata  in  DATA_W  store data
- stall  out  1  hold bundle this cycle (combinational)
- r0_valid/r1_valid  out  1  load data valid for slot
- r0_data/r1_data  out  DATA_W  load data
- ram_ena, ram_wea  out  1  port A enable/write
- ram_addra  out  ADDR_W; ram_dia  out  DATA_W
- ram_enb  out  1; ram_addrb  out  ADDR_W; ram_dob  in  DATA_W
- oob_err  out  1  sticky out-of-range flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=RUN; replay register cleared; r*_valid=0; r*_data=0; oob_err=0; all ram enables 0. Reset mid-replay drops the deferred op.
- FSM RUN:
  - Conflict when both slots request and any of the following holds:
    - both are stores;
    - both are loads;
    - slot0 load and slot1 store to the same address.
  - On conflict: issue slot0 now, latch slot1 (we, addr, wdata) into the replay register, stall=1, go to REPLAY.
  - No conflict: issue both, stall=0.
- FSM REPLAY:
  - Ignore the inputs; the bundle is still held.
  - Issue the latched slot1 op, stall=0, go to RUN.
- Issue rules:
  - Store: ram_ena=ram_wea=1, with address and data driven the same cycle.
  - Load: ram_enb=1, ram_addrb=addr.
  - Load result: r*_valid=1 exactly one cycle after issue; r*_data=ram_dob.
- Forwarding: slot0 store and slot1 load to the same address in one RUN cycle → both issue; slot1 gets slot0 wdata.
  - Forward select and data are registered with the issue, so r1_data is muxed in the return cycle. Do not read the BRAM for that load (ram_enb=0).
- Write then read of the same address in consecutive cycles needs no forwarding; the BRAM returns the new value.
- Out-of-range op (addr >= DEPTH):
  - Store: suppressed.
  - Load: returns 0 with valid=1, no RAM access.
  - oob_err set; it clears only on reset.
- An out-of-range op still participates in conflict detection.
- req=0 slot: no RAM activity and no valid.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds output ports stall_cnt and fwd_cnt (32 bits each).
  - stall_cnt increments on each cycle stall=1; fwd_cnt increments on each forward.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; no other behaviour changes.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {RUN, REPLAY};
  - memory-op struct {we, addr, wdata};
  - DEPTH default constant.
- Optional sub-module dmem_conflict_detect: combinational; slot0/slot1 ops in → conflict, forward flags out.
- Replay register, FSM and return path stay in the top module.

Test Plan:
- s0 store 0x10=0xAAAA and s1 load 0x20 (mem[0x20]=0x55) → stall=0; next cycle r1_valid=1, r1_data=0x55; mem[0x10]=0xAAAA.
- s0 load 0x8 and s1 load 0x9 → stall=1 one cycle; r0 valid at t+1 and r1 valid at t+2 with correct data; exactly one ram_enb per cycle.
- s0 store 0x30=0x1234 and s1 load 0x30 → no stall; ram_enb=0; r1_data=0x1234 at t+1.
- s0 load 0x40 (old 0x7) and s1 store 0x40=0x9 → stall 1 cycle; r0_data=0x7; mem[0x40]=0x9 after REPLAY.
- s0 store to address 140001 → no write; oob_err=1 and stays 1; load to 140001 returns 0 with valid.
- Assert rst during REPLAY → outputs return to reset values immediately; deferred store never reaches RAM; with DMEM_ARB_STATS_EN, counters read 0.
